dram_bank_ctrl: RTL and testbench

Parametrised multi-bank DRAM front-end controller for the matrix-multiplication datapath. It accepts single-beat read/write requests over a valid/ready handshake and decodes the bank from the upper address bits. It drives a registered one-hot bank enable with local address, write enable and write data. It returns read data after a fixed bank latency, tagged with the bank index, and enforces a per-bank write-to-read turnaround.

---
 rtl/dram_bank_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_dram_bank_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dram_bank_ctrl.sv
// dram_bank_ctrl: multi-bank DRAM front end. Accepts one read/write request
// per cycle, decodes the bank from the upper address bits, issues a
// registered one-hot bank enable, returns read data after RD_LAT cycles and
// stalls reads to a bank that was just written.
// Optional refresh engine: define DRAM_BANK_CTRL_REFRESH_EN.
module dram_bank_ctrl #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned NUM_BANKS  = 4,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned WTR_CYC    = 1,
    parameter int unsigned REF_PERIOD = 64,
    parameter int unsigned REF_CYC    = 4,
    localparam int unsigned BANK_BITS = $clog2(NUM_BANKS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [ADDR_W-1:0]              req_addr,
    input  logic                           req_we,
    input  logic [DATA_W-1:0]              req_wdata,
    output logic [NUM_BANKS-1:0]           bank_en,
    output logic                           bank_we,
    output logic [ADDR_W-BANK_BITS-1:0]    bank_addr,
    output logic [DATA_W-1:0]              bank_wdata,
    input  logic [NUM_BANKS*DATA_W-1:0]    bank_rdata,
    output logic                           rd_valid,
    output logic [DATA_W-1:0]              rd_data,
    output logic [BANK_BITS-1:0]           rd_bank,
    output logic                           busy
`ifdef DRAM_BANK_CTRL_REFRESH_EN
    ,
    output logic                           refresh_active
`endif
);

    localparam int unsigned LOC_W = ADDR_W - BANK_BITS;
    localparam int unsigned WTR_W = (WTR_CYC > 0) ? $clog2(WTR_CYC + 1) : 1;

    logic [BANK_BITS-1:0]  req_bank;
    logic [LOC_W-1:0]      req_loc;
    logic                  rd_stall;
    logic                  accept;
    logic                  ref_block;
    logic                  ref_busy;
    logic                  wtr_any;

    logic [NUM_BANKS-1:0]  bank_en_q;
    logic                  bank_we_q;
    logic [LOC_W-1:0]      bank_addr_q;
    logic [DATA_W-1:0]     bank_wdata_q;
    logic                  issue_rd_q;
    logic [BANK_BITS-1:0]  issue_bank_q;

    logic [WTR_W-1:0]      wtr_cnt_q [NUM_BANKS];
    logic [WTR_W-1:0]      wtr_cnt_d [NUM_BANKS];

    logic [RD_LAT-1:0]     pipe_vld_q;
    logic [BANK_BITS-1:0]  pipe_bank_q [RD_LAT];
    logic [DATA_W-1:0]     rdata_slice [NUM_BANKS];

    logic                  rd_valid_q;
    logic [DATA_W-1:0]     rd_data_q;
    logic [BANK_BITS-1:0]  rd_bank_q;

    assign req_bank = req_addr[ADDR_W-1 -: BANK_BITS];
    assign req_loc  = req_addr[LOC_W-1:0];

    // Handshake: reads to a bank still in write-to-read turnaround are held off.
    always_comb begin
        rd_stall  = req_valid && !req_we && (wtr_cnt_q[req_bank] != '0);
        req_ready = !rst && !rd_stall && !ref_block;
        accept    = req_valid && req_ready;
    end

    // Issue stage: one-cycle bank strobe after each accept; address/data hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_en_q    <= '0;
            bank_we_q    <= 1'b0;
            bank_addr_q  <= '0;
            bank_wdata_q <= '0;
            issue_rd_q   <= 1'b0;
            issue_bank_q <= '0;
        end else begin
            bank_en_q  <= accept ? (NUM_BANKS'(1) << req_bank) : '0;
            bank_we_q  <= accept && req_we;
            issue_rd_q <= accept && !req_we;
            if (accept) begin
                bank_addr_q  <= req_loc;
                bank_wdata_q <= req_wdata;
                issue_bank_q <= req_bank;
            end
        end
    end

    // Turnaround counters: a write reloads its bank, nonzero counters count down.
    always_comb begin
        wtr_any = 1'b0;
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            wtr_cnt_d[i] = wtr_cnt_q[i];
            if (accept && req_we && (req_bank == BANK_BITS'(i))) begin
                wtr_cnt_d[i] = WTR_W'(WTR_CYC);
            end else if (wtr_cnt_q[i] != '0) begin
                wtr_cnt_d[i] = wtr_cnt_q[i] - WTR_W'(1);
            end
            if (wtr_cnt_q[i] != '0) begin
                wtr_any = 1'b1;
            end
        end
    end

    // Turnaround counter registers.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            wtr_cnt_q[i] <= rst ? '0 : wtr_cnt_d[i];
        end
    end

    // Split the concatenated read bus into per-bank words.
    always_comb begin
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            rdata_slice[i] = bank_rdata[i*DATA_W +: DATA_W];
        end
    end

    // Read pipeline: stage 0 follows the bank_en cycle, the last stage marks
    // the cycle whose bank_rdata is captured into the return registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld_q <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                pipe_bank_q[i] <= '0;
            end
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_bank_q  <= '0;
        end else begin
            pipe_vld_q[0]  <= issue_rd_q;
            pipe_bank_q[0] <= issue_bank_q;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_bank_q[i] <= pipe_bank_q[i-1];
            end
            rd_valid_q <= pipe_vld_q[RD_LAT-1];
            if (pipe_vld_q[RD_LAT-1]) begin
                rd_data_q <= rdata_slice[pipe_bank_q[RD_LAT-1]];
                rd_bank_q <= pipe_bank_q[RD_LAT-1];
            end
        end
    end

`ifdef DRAM_BANK_CTRL_REFRESH_EN
    localparam int unsigned REF_W = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
    localparam int unsigned RC_W  = (REF_CYC > 1) ? $clog2(REF_CYC) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_REFRESH
    } ref_state_e;

    ref_state_e        state_q, state_d;
    logic [REF_W-1:0]  ref_cnt_q, ref_cnt_d;
    logic              ref_pend_q, ref_pend_d;
    logic [RC_W-1:0]   ref_left_q, ref_left_d;
    logic              rd_inflight;
    logic              period_hit;

    // Refresh FSM next state: the pending flag is sticky until REFRESH is
    // entered, which also restarts the period counter.
    always_comb begin
        state_d     = state_q;
        ref_left_d  = ref_left_q;
        rd_inflight = issue_rd_q || (pipe_vld_q != '0);
        period_hit  = (ref_cnt_q == REF_W'(REF_PERIOD - 1));
        ref_cnt_d   = period_hit ? '0 : ref_cnt_q + REF_W'(1);
        ref_pend_d  = ref_pend_q || period_hit;
        unique case (state_q)
            ST_IDLE: begin
                if (ref_pend_q && !rd_inflight) begin
                    state_d    = ST_REFRESH;
                    ref_left_d = RC_W'(REF_CYC - 1);
                    ref_pend_d = 1'b0;
                    ref_cnt_d  = '0;
                end
            end
            ST_REFRESH: begin
                if (ref_left_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    ref_left_d = ref_left_q - RC_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Refresh FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ref_cnt_q  <= '0;
            ref_pend_q <= 1'b0;
            ref_left_q <= '0;
        end else begin
            state_q    <= state_d;
            ref_cnt_q  <= ref_cnt_d;
            ref_pend_q <= ref_pend_d;
            ref_left_q <= ref_left_d;
        end
    end

    assign refresh_active = (state_q == ST_REFRESH);
    assign ref_block      = ref_pend_q || refresh_active;
    assign ref_busy       = ref_pend_q || refresh_active;
    assign bank_en        = refresh_active ? '1 : bank_en_q;
`else
    assign ref_block = 1'b0;
    assign ref_busy  = 1'b0;
    assign bank_en   = bank_en_q;
`endif

    assign bank_we    = bank_we_q;
    assign bank_addr  = bank_addr_q;
    assign bank_wdata = bank_wdata_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign rd_bank    = rd_bank_q;
    assign busy       = issue_rd_q || (pipe_vld_q != '0) || wtr_any || ref_busy;

endmodule

// File: tb/tb_dram_bank_ctrl.sv
// Directed bench for dram_bank_ctrl (default parameters, refresh disabled).
module tb_dram_bank_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_addr;
    logic        req_we;
    logic [7:0]  req_wdata;
    logic [3:0]  bank_en;
    logic        bank_we;
    logic [5:0]  bank_addr;
    logic [7:0]  bank_wdata;
    logic [31:0] bank_rdata;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic [1:0]  rd_bank;
    logic        busy;
`ifdef DRAM_BANK_CTRL_REFRESH_EN
    logic        refresh_active;
`endif

    dram_bank_ctrl #(
        .ADDR_W    (8),
        .NUM_BANKS (4),
        .DATA_W    (8),
        .RD_LAT    (2),
        .WTR_CYC   (1),
        .REF_PERIOD(64),
        .REF_CYC   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_wdata (req_wdata),
        .bank_en   (bank_en),
        .bank_we   (bank_we),
        .bank_addr (bank_addr),
        .bank_wdata(bank_wdata),
        .bank_rdata(bank_rdata),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_bank   (rd_bank),
        .busy      (busy)
`ifdef DRAM_BANK_CTRL_REFRESH_EN
        ,
        .refresh_active(refresh_active)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        v;
        logic        we;
        logic [7:0]  addr;
        logic [7:0]  wd;
        logic [31:0] rdata;
        logic        rdy;
        logic [3:0]  en;
        logic        bwe;
        logic [5:0]  baddr;
        logic [7:0]  bwd;
        logic        rv;
        logic [7:0]  rd;
        logic [1:0]  rb;
        logic        busy;
    } vec_t;

    vec_t        vecs[$];
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    localparam logic [31:0] D0 = 32'h4433_2211;
    localparam logic [31:0] R9 = 32'h4433_3C11;

    function automatic vec_t mk(
        input logic [31:0] r, v, we, addr, wd, rdata,
        input logic [31:0] rdy, en, bwe, baddr, bwd, rv, rd, rb, bz);
        vec_t t;
        t.rst   = r[0];
        t.v     = v[0];
        t.we    = we[0];
        t.addr  = addr[7:0];
        t.wd    = wd[7:0];
        t.rdata = rdata;
        t.rdy   = rdy[0];
        t.en    = en[3:0];
        t.bwe   = bwe[0];
        t.baddr = baddr[5:0];
        t.bwd   = bwd[7:0];
        t.rv    = rv[0];
        t.rd    = rd[7:0];
        t.rb    = rb[1:0];
        t.busy  = bz[0];
        return t;
    endfunction

    task automatic chk(input string name, input int row,
                       input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, got, exp);
    endtask

    // Drive one cycle of inputs just after the rising edge, return at the
    // falling edge so outputs are sampled mid-cycle.
    task automatic apply(input vec_t t);
        @(posedge clk);
        #1;
        rst        = t.rst;
        req_valid  = t.v;
        req_we     = t.we;
        req_addr   = t.addr;
        req_wdata  = t.wd;
        bank_rdata = t.rdata;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int got_k;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        bank_rdata = D0;

        //          rst v we addr   wd     rdata | rdy en      bwe baddr bwd    rv rd     rb busy
        vecs.push_back(mk(1, 1, 0, 'h05, 'h00, D0,  0, 'b0000, 0, 0, 'h00, 0, 'h00, 0, 0)); // c0
        vecs.push_back(mk(1, 1, 0, 'h05, 'h00, D0,  0, 'b0000, 0, 0, 'h00, 0, 'h00, 0, 0));
        vecs.push_back(mk(1, 1, 0, 'h05, 'h00, D0,  0, 'b0000, 0, 0, 'h00, 0, 'h00, 0, 0));
        vecs.push_back(mk(0, 1, 1, 'h05, 'hA5, D0,  1, 'b0000, 0, 0, 'h00, 0, 'h00, 0, 0)); // c3
        vecs.push_back(mk(0, 1, 1, 'hC5, 'h5A, D0,  1, 'b0001, 1, 5, 'hA5, 0, 'h00, 0, 1));
        vecs.push_back(mk(0, 0, 0, 'h00, 'h00, D0,  1, 'b1000, 1, 5, 'h5A, 0, 'h00, 0, 1));
        vecs.push_back(mk(0, 1, 0, 'h45, 'h00, D0,  1, 'b0000, 0, 5, 'h5A, 0, 'h00, 0, 0)); // c6
        vecs.push_back(mk(0, 0, 0, 'h00, 'h00, D0,  1, 'b0010, 0, 5, 'h00, 0, 'h00, 0, 1));
        vecs.push_back(mk(0, 0, 0, 'h00, 'h00, D0,  1, 'b0000, 0, 5, 'h00, 0, 'h00, 0, 1));
        vecs.push_back(mk(0, 0, 0, 'h00, 'h00, R9,  1, 'b0000, 0, 5, 'h00, 0, 'h00, 0, 1)); // c9
        vecs.push_back(mk(0, 1, 0, 'h01, 'h00, D0,  1, 'b0000, 0, 5, 'h00, 1, 'h3C, 1, 0));
        vecs.push_back(mk(0, 1, 0, 'h42, 'h00, D0,  1, 'b0001, 0, 1, 'h00, 0, 'h3C, 1, 1));
        vecs.push_back(mk(0, 1, 0, 'h83, 'h00, D0,  1, 'b0010, 0, 2, 'h00, 0, 'h3C, 1, 1));
        vecs.push_back(mk(0, 1, 0, 'hC4, 'h00, D0,  1, 'b0100, 0, 3, 'h00, 0, 'h3C, 1, 1));
        vecs.push_back(mk(0, 0, 0, 'h00, 'h00, D0,  1, 'b1000, 0, 4, 'h00, 1, 'h11, 0, 1)); // c14
        vecs.push_back(mk(0, 0, 0, 'h00, 'h00, D0,  1, 'b0000, 0, 4, 'h00, 1, 'h22, 1, 1));
        vecs.push_back(mk(0, 0, 0, 'h00, 'h00, D0,  1, 'b0000, 0, 4, 'h00, 1, 'h33, 2, 1));
        vecs.push_back(mk(0, 0, 0, 'h00, 'h00, D0,  1, 'b0000, 0, 4, 'h00, 1, 'h44, 3, 0));
        vecs.push_back(mk(0, 1, 1, 'h80, 'h77, D0,  1, 'b0000, 0, 4, 'h00, 0, 'h44, 3, 0)); // c18
        vecs.push_back(mk(0, 1, 0, 'h81, 'h00, D0,  0, 'b0100, 1, 0, 'h77, 0, 'h44, 3, 1));
        vecs.push_back(mk(0, 1, 0, 'h81, 'h00, D0,  1, 'b0000, 0, 0, 'h77, 0, 'h44, 3, 0));
        vecs.push_back(mk(0, 1, 1, 'h82, 'h66, D0,  1, 'b0100, 0, 1, 'h00, 0, 'h44, 3, 1));
        vecs.push_back(mk(0, 1, 0, 'hC7, 'h00, D0,  1, 'b0100, 1, 2, 'h66, 0, 'h44, 3, 1)); // c22
        vecs.push_back(mk(0, 0, 0, 'h00, 'h00, D0,  1, 'b1000, 0, 7, 'h00, 0, 'h44, 3, 1));
        vecs.push_back(mk(0, 0, 0, 'h00, 'h00, D0,  1, 'b0000, 0, 7, 'h00, 1, 'h33, 2, 1));
        vecs.push_back(mk(0, 0, 0, 'h00, 'h00, D0,  1, 'b0000, 0, 7, 'h00, 0, 'h33, 2, 1));
        vecs.push_back(mk(0, 0, 0, 'h00, 'h00, D0,  1, 'b0000, 0, 7, 'h00, 1, 'h44, 3, 0));
        vecs.push_back(mk(0, 0, 0, 'h00, 'h00, D0,  1, 'b0000, 0, 7, 'h00, 0, 'h44, 3, 0));
        vecs.push_back(mk(0, 1, 0, 'h41, 'h00, D0,  1, 'b0000, 0, 7, 'h00, 0, 'h44, 3, 0)); // c28
        vecs.push_back(mk(1, 0, 0, 'h00, 'h00, D0,  0, 'b0010, 0, 1, 'h00, 0, 'h44, 3, 1));
        vecs.push_back(mk(0, 0, 0, 'h00, 'h00, D0,  1, 'b0000, 0, 0, 'h00, 0, 'h00, 0, 0));
        vecs.push_back(mk(0, 0, 0, 'h00, 'h00, D0,  1, 'b0000, 0, 0, 'h00, 0, 'h00, 0, 0));
        vecs.push_back(mk(0, 0, 0, 'h00, 'h00, D0,  1, 'b0000, 0, 0, 'h00, 0, 'h00, 0, 0));

        foreach (vecs[i]) begin
            apply(vecs[i]);
            chk("req_ready",  i, 32'(req_ready),  32'(vecs[i].rdy));
            chk("bank_en",    i, 32'(bank_en),    32'(vecs[i].en));
            chk("bank_we",    i, 32'(bank_we),    32'(vecs[i].bwe));
            chk("bank_addr",  i, 32'(bank_addr),  32'(vecs[i].baddr));
            chk("bank_wdata", i, 32'(bank_wdata), 32'(vecs[i].bwd));
            chk("rd_valid",   i, 32'(rd_valid),   32'(vecs[i].rv));
            chk("rd_data",    i, 32'(rd_data),    32'(vecs[i].rd));
            chk("rd_bank",    i, 32'(rd_bank),    32'(vecs[i].rb));
            chk("busy",       i, 32'(busy),       32'(vecs[i].busy));
        end

        // Same-bank back-to-back reads, return latency measured with a bound.
        apply(mk(0, 1, 0, 'h03, 'h00, D0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("seq_rdy_first", 100, 32'(req_ready), 32'd1);
        apply(mk(0, 1, 0, 'h07, 'h00, D0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("seq_rdy_same_bank", 101, 32'(req_ready), 32'd1);
        chk("seq_en_first", 101, 32'(bank_en), 32'h1);
        chk("seq_addr_first", 101, 32'(bank_addr), 32'd3);
        got_k = 0;
        for (int k = 1; k <= 10; k++) begin
            apply(mk(0, 0, 0, 'h00, 'h00, D0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            if (rd_valid) begin
                got_k = k;
                break;
            end
        end
        chk("seq_rd_latency", 102, 32'(got_k), 32'd3);
        chk("seq_rd_data", 102, 32'(rd_data), 32'h11);
        chk("seq_rd_bank", 102, 32'(rd_bank), 32'd0);
        apply(mk(0, 0, 0, 'h00, 'h00, D0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("seq_rd_valid_second", 103, 32'(rd_valid), 32'd1);
        chk("seq_rd_bank_second", 103, 32'(rd_bank), 32'd0);
        apply(mk(0, 0, 0, 'h00, 'h00, D0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("seq_rd_valid_end", 104, 32'(rd_valid), 32'd0);
        chk("seq_busy_end", 104, 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
